// File: rtl/epass_validator.sv
// rtl/epass_validator.sv - E-pass stay timer, fee calculator, card validator and debit responder
// Optional card top-up port is enabled by defining EPASS_TOPUP_EN.
module epass_validator #(
  parameter int N_CARDS      = 8,
  parameter int ID_W         = 3,
  parameter int BAL_W        = 12,
  parameter int FEE_W        = 8,
  parameter int UNIT_W       = 6,
  parameter int BASE_FEE     = 5,
  parameter int RATE         = 2,
  parameter int INIT_BALANCE = 100,
  parameter int TIMEOUT      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             count,
  input  logic             cal,
  input  logic             tick,
  input  logic             card_valid,
  input  logic [ID_W-1:0]  card_id,
  input  logic             wr_en,
  input  logic [ID_W-1:0]  wr_addr,
  input  logic [BAL_W-1:0] wr_data,
  output logic [1:0]       valid_Epass,
  output logic [FEE_W-1:0] fee,
  output logic             busy
);

  localparam int FW    = FEE_W + UNIT_W + 1;
  localparam int BW1   = BAL_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [FEE_W-1:0]  FEE_MAX  = '1;
  localparam logic [BAL_W-1:0]  BAL_MAX  = '1;
  localparam logic [UNIT_W-1:0] UNIT_MAX = '1;
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CARD,
    S_LOOKUP,
    S_ACCEPT,
    S_REJECT
  } state_t;

  state_t            r_state;
  logic [1:0]        r_valid;
  logic [FEE_W-1:0]  r_fee;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;
  logic [ID_W-1:0]   r_id;
  logic [UNIT_W-1:0] r_elapsed;
  logic [BAL_W-1:0]  r_balance [N_CARDS];

  logic [FW-1:0]     w_fee_wide;
  logic [FEE_W-1:0]  w_fee;
  logic [BAL_W-1:0]  w_bal_sel;
  logic              w_id_ok;
  logic              w_afford;
  logic [BW1-1:0]    w_sum     [N_CARDS];
  logic [BAL_W-1:0]  w_bal_nxt [N_CARDS];

  assign valid_Epass = r_valid;
  assign fee         = r_fee;
  assign busy        = r_busy;

  // Wide enough that RATE*elapsed cannot wrap before the clamp.
  assign w_fee_wide = FW'(BASE_FEE) + FW'(RATE) * FW'(r_elapsed);
  assign w_fee      = (w_fee_wide > FW'(FEE_MAX)) ? FEE_MAX : w_fee_wide[FEE_W-1:0];

  always_comb begin
    w_bal_sel = '0;
    for (int i = 0; i < N_CARDS; i++) begin
      if (r_id == ID_W'(i)) w_bal_sel = r_balance[i];
    end
  end

  assign w_id_ok  = (int'({1'b0, r_id}) < N_CARDS);
  assign w_afford = (w_bal_sel >= BAL_W'(r_fee));

  // Debit and top-up for a card are merged so both land in the same cycle.
  always_comb begin
    for (int i = 0; i < N_CARDS; i++) begin
      w_sum[i] = {1'b0, r_balance[i]};
`ifdef EPASS_TOPUP_EN
      if (wr_en && wr_addr == ID_W'(i)) w_sum[i] = w_sum[i] + {1'b0, wr_data};
`endif
      if (r_state == S_ACCEPT && r_id == ID_W'(i)) w_sum[i] = w_sum[i] - BW1'(r_fee);
      w_bal_nxt[i] = (w_sum[i] > {1'b0, BAL_MAX}) ? BAL_MAX : w_sum[i][BAL_W-1:0];
    end
  end

`ifndef EPASS_TOPUP_EN
  logic w_unused_wr;
  assign w_unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CARDS; i++) r_balance[i] <= BAL_W'(INIT_BALANCE);
    end else begin
      for (int i = 0; i < N_CARDS; i++) r_balance[i] <= w_bal_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || init) begin
      r_elapsed <= '0;
    end else if (count && tick && r_elapsed != UNIT_MAX) begin
      r_elapsed <= r_elapsed + UNIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= 2'b00;
      r_fee   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_id    <= '0;
    end else begin
      r_valid <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (cal) begin
            r_state <= S_WAIT_CARD;
            r_fee   <= w_fee;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_CARD: begin
          if (!cal) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (card_valid) begin
            r_id    <= card_id;
            r_state <= S_LOOKUP;
          end else if (tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == TO_LAST) begin
              r_state <= S_REJECT;
              r_valid <= 2'b01;
            end
          end
        end
        S_LOOKUP: begin
          if (!cal) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_id_ok && w_afford) begin
            r_state <= S_ACCEPT;
            r_valid <= 2'b10;
          end else begin
            r_state <= S_REJECT;
            r_valid <= 2'b01;
          end
        end
        // Verdict is already on the output; the transaction completes regardless of cal.
        S_ACCEPT, S_REJECT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_epass_validator.sv
// tb/tb_epass_validator.sv - scoreboard bench for epass_validator
// Verdicts are queued when a card or timeout is driven and popped when the DUT pulses.
module tb_epass_validator;

  localparam int NC = 6;

  typedef struct {
    logic [1:0] verdict;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, init, count, cal, tick, card_valid, wr_en;
  logic [2:0]  card_id, wr_addr;
  logic [11:0] wr_data;
  logic [1:0]  valid_Epass;
  logic [7:0]  fee;
  logic        busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   e_m      = 0;
  int   bal_m [NC];
  exp_t sb [$];

  epass_validator #(.N_CARDS(NC)) dut (
    .clk(clk), .reset(reset), .init(init), .count(count), .cal(cal), .tick(tick),
    .card_valid(card_valid), .card_id(card_id), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .valid_Epass(valid_Epass), .fee(fee), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int fee_of(input int e);
    int v;
    v = 5 + 2 * e;
    return (v > 255) ? 255 : v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (valid_Epass != 2'b00) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_verdict", valid_Epass, 0);
      end else begin
        e = sb.pop_front();
        check_eq("verdict", valid_Epass, e.verdict);
        check_eq("verdict_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic time_stay(input int n);
    init = 1'b1; step(); init = 1'b0;
    count = 1'b1;
    repeat (n) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    count = 1'b0;
    e_m = (n > 63) ? 63 : n;
  endtask

  function automatic logic [1:0] expect_card(input int id);
    int f;
    f = fee_of(e_m);
    if (id < NC && bal_m[id] >= f) begin
      bal_m[id] -= f;
      return 2'b10;
    end
    return 2'b01;
  endfunction

  task automatic txn(input int id);
    logic [1:0] ev;
    cal = 1'b1; step();
    check_eq("fee", fee, fee_of(e_m));
    check_eq("busy", busy, 1);
    ev = expect_card(id);
    card_valid = 1'b1; card_id = id[2:0];
    sb.push_back('{ev, cyc + 2});
    step(); card_valid = 1'b0;
    step(); cal = 1'b0;
    step(); step();
    check_eq("busy_after", busy, 0);
    if (id < NC) check_eq("balance", dut.r_balance[id], bal_m[id]);
  endtask

  task automatic wait_timeout(input bit card_last, input int id);
    logic [1:0] ev;
    cal = 1'b1; step();
    repeat (9) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    tick = 1'b1;
    if (card_last) begin
      ev = expect_card(id);
      card_valid = 1'b1; card_id = id[2:0];
      sb.push_back('{ev, cyc + 2});
      step(); tick = 1'b0; card_valid = 1'b0;
      step();
    end else begin
      sb.push_back('{2'b01, cyc + 1});
      step(); tick = 1'b0;
    end
    cal = 1'b0; step(); step();
    check_eq("busy_after_to", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; init = 1'b0; count = 1'b0; cal = 1'b0; tick = 1'b0;
    card_valid = 1'b0; card_id = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < NC; i++) bal_m[i] = 100;
    step(); step(); reset = 1'b0; step();

    check_eq("rst_valid", valid_Epass, 0);
    check_eq("rst_fee", fee, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bal0", dut.r_balance[0], 100);

    // Basic accept: 10 units -> fee 25
    time_stay(10);
    txn(3);
    check_eq("card3_75", dut.r_balance[3], 75);

    // Drain card 1 to 20, then a fee of 25 is rejected
    txn(1); txn(1); txn(1);
    time_stay(0);
    txn(1);
    time_stay(10);
    txn(1);
    check_eq("card1_20", dut.r_balance[1], 20);

    // Balance exactly equal to fee is accepted and reaches zero
    txn(2); txn(2); txn(2); txn(2);
    check_eq("card2_0", dut.r_balance[2], 0);

    // Out-of-range card IDs
    txn(7);
    txn(6);
    check_eq("card0_untouched", dut.r_balance[0], 100);

    // Timeout reject, then card on the 10th tick beats the timeout
    wait_timeout(1'b0, 0);
    check_eq("card0_after_to", dut.r_balance[0], 100);
    wait_timeout(1'b1, 0);
    check_eq("card0_card_wins", dut.r_balance[0], 75);

    // Abort in WAIT_CARD and in LOOKUP
    cal = 1'b1; step(); cal = 1'b0; step();
    check_eq("abort_wait_busy", busy, 0);
    step();
    cal = 1'b1; step();
    card_valid = 1'b1; card_id = 3'd4; step();
    card_valid = 1'b0; cal = 1'b0; step();
    check_eq("abort_lookup_busy", busy, 0);
    step(); step();
    check_eq("abort_card4", dut.r_balance[4], 100);

    // Elapsed saturates at 63 -> fee 131, card 4 cannot afford it
    time_stay(70);
    txn(4);
    check_eq("sat_card4", dut.r_balance[4], 100);

    // Reset during ACCEPT discards the debit
    time_stay(10);
    cal = 1'b1; step();
    card_valid = 1'b1; card_id = 3'd5;
    sb.push_back('{2'b10, cyc + 2});
    step(); card_valid = 1'b0;
    step(); reset = 1'b1; cal = 1'b0;
    step(); step(); reset = 1'b0; step();
    for (int i = 0; i < NC; i++) begin
      bal_m[i] = 100;
      check_eq("post_rst_bal", dut.r_balance[i], 100);
    end
    e_m = 0;
    check_eq("post_rst_fee", fee, 0);
    check_eq("post_rst_busy", busy, 0);

`ifdef EPASS_TOPUP_EN
    // Same-cycle debit and top-up on card 2: 100 - 25 + 50
    time_stay(10);
    cal = 1'b1; step();
    card_valid = 1'b1; card_id = 3'd2;
    sb.push_back('{2'b10, cyc + 2});
    step(); card_valid = 1'b0;
    step(); cal = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 12'd50;
    step(); wr_en = 1'b0;
    step();
    check_eq("topup_card2", dut.r_balance[2], 125);
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 12'd9; step(); wr_en = 1'b0; step();
    check_eq("topup_oob_card0", dut.r_balance[0], 100);
`endif

    step(); step();
    check_eq("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
